// File: rtl/time_scheduler.sv
// Shared time-base scheduler: serially scans the posted next-edge times, issues the
// minimum as the new emulated time with a one-cycle step strobe and a hit mask.
module time_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIME_W  = 64,
  parameter int SETTLE  = 2
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TIME_W-1:0] req_time,
  output logic [TIME_W-1:0]         time_next,
  output logic                      step,
  output logic [NUM_REQ-1:0]        hit_mask,
  output logic                      busy,
  output logic                      err_back
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_ISSUE  = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIME_W-1:0]    min_q, min_d;
  logic [NUM_REQ-1:0]   mask_q, mask_d;
  logic                 any_q, any_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic                 step_q, step_d;
  logic [NUM_REQ-1:0]   hit_q, hit_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [TIME_W-1:0]    cur_time_s;
  logic                 cur_valid_s;
  logic [NUM_REQ-1:0]   onehot_s;
  logic                 start_ok_s;

  assign start_ok_s = run & ~stall;

  always_comb begin
    cur_time_s  = '0;
    cur_valid_s = 1'b0;
    onehot_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_time_s  = req_time[i*TIME_W +: TIME_W];
        cur_valid_s = req_valid[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    mask_d  = mask_q;
    any_d   = any_q;
    time_d  = time_q;
    step_d  = 1'b0;
    hit_d   = hit_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = S_SCAN;
          idx_d   = '0;
          min_d   = '1;
          any_d   = 1'b0;
          mask_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        // Ties only add bits; a strictly smaller time replaces the running minimum.
        if (cur_valid_s) begin
          if (!any_q || (cur_time_s < min_q)) begin
            min_d  = cur_time_s;
            mask_d = onehot_s;
            any_d  = 1'b1;
          end else if (cur_time_s == min_q) begin
            mask_d = mask_q | onehot_s;
          end else begin
            mask_d = mask_q;
          end
        end else begin
          mask_d = mask_q;
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_ISSUE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ISSUE: begin
        if (any_q) begin
          time_d = min_q;
          hit_d  = mask_q;
          step_d = 1'b1;
          if (min_q < time_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          time_d = time_q;
        end
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          if (start_ok_s) begin
            state_d = S_SCAN;
            idx_d   = '0;
            min_d   = '1;
            any_d   = 1'b0;
            mask_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      min_q   <= '1;
      mask_q  <= '0;
      any_q   <= 1'b0;
      time_q  <= '0;
      step_q  <= 1'b0;
      hit_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      mask_q  <= mask_d;
      any_q   <= any_d;
      time_q  <= time_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign time_next = time_q;
  assign step      = step_q;
  assign hit_mask  = hit_q;
  assign busy      = busy_q;
  assign err_back  = err_q;

endmodule

// File: tb/tb_time_scheduler.sv
// Directed bench for time_scheduler: inputs driven and outputs sampled on the falling
// edge of clk_sys, expected values worked out by hand for NUM_REQ=4, SETTLE=2.
module tb_time_scheduler;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic         run;
  logic         stall;
  logic [3:0]   req_valid;
  logic [255:0] req_time;
  logic [63:0]  time_next;
  logic         step;
  logic [3:0]   hit_mask;
  logic         busy;
  logic         err_back;

  int checks   = 0;
  int failures = 0;
  int n;
  int steps_seen;
  int idle_seen;

  always #5 clk_sys = ~clk_sys;

  time_scheduler #(.NUM_REQ(4), .TIME_W(64), .SETTLE(2)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .run       (run),
    .stall     (stall),
    .req_valid (req_valid),
    .req_time  (req_time),
    .time_next (time_next),
    .step      (step),
    .hit_mask  (hit_mask),
    .busy      (busy),
    .err_back  (err_back)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_times(input logic [63:0] t0, input logic [63:0] t1,
                           input logic [63:0] t2, input logic [63:0] t3);
    req_time = {t3, t2, t1, t0};
  endtask

  // Counts falling edges until step is seen, bounded by max.
  task automatic wait_step(input string tag, input int max, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_sys);
      cnt++;
    end while (step !== 1'b1 && cnt < max);
    chk({tag, "_seen"}, {63'd0, step}, 64'd1);
  endtask

  task automatic watch(input int cycles, output int nsteps, output int nidle);
    nsteps = 0;
    nidle  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (step === 1'b1) nsteps++;
      if (busy === 1'b0) nidle++;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0; req_valid = 4'b0000;
    set_times(64'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk_sys);
    chk("rst_time", time_next, 64'd0);
    chk("rst_step", {63'd0, step}, 64'd0);
    chk("rst_hit", {60'd0, hit_mask}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err_back}, 64'd0);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // T1: single minimum, latency from run to step = 1 (IDLE) + NUM_REQ + 1
    set_times(64'd30, 64'd10, 64'd20, 64'd40);
    req_valid = 4'b1111;
    run = 1'b1;
    wait_step("t1", 20, n);
    chk("t1_lat", n, 64'd6);
    chk("t1_time", time_next, 64'd10);
    chk("t1_hit", {60'd0, hit_mask}, 64'd2);
    chk("t1_err", {63'd0, err_back}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk_sys);
    chk("t1_pulse", {63'd0, step}, 64'd0);
    wait_step("t1_re", 20, n);
    chk("t1_period", n + 1, 64'd7);
    chk("t1_eq_time", time_next, 64'd10);
    chk("t1_eq_err", {63'd0, err_back}, 64'd0);

    // T2: three-way tie accumulates into the mask
    set_times(64'd25, 64'd25, 64'd90, 64'd25);
    wait_step("t2", 20, n);
    chk("t2_period", n, 64'd7);
    chk("t2_time", time_next, 64'd25);
    chk("t2_hit", {60'd0, hit_mask}, 64'd11);
    @(negedge clk_sys);
    chk("t2_pulse", {63'd0, step}, 64'd0);

    // T3: nobody valid, FSM keeps cycling without steps
    req_valid = 4'b0000;
    watch(20, steps_seen, idle_seen);
    chk("t3_steps", steps_seen, 64'd0);
    chk("t3_idle", idle_seen, 64'd0);
    chk("t3_time", time_next, 64'd25);
    chk("t3_hit", {60'd0, hit_mask}, 64'd11);
    run = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("t3_stop_busy", {63'd0, busy}, 64'd0);

    // T4: time going backwards sets a sticky error
    set_times(64'd50, 64'd60, 64'd70, 64'd80);
    req_valid = 4'b1111;
    run = 1'b1;
    wait_step("t4a", 20, n);
    chk("t4a_time", time_next, 64'd50);
    chk("t4a_hit", {60'd0, hit_mask}, 64'd1);
    chk("t4a_err", {63'd0, err_back}, 64'd0);
    set_times(64'd45, 64'd40, 64'd99, 64'd41);
    wait_step("t4b", 20, n);
    chk("t4b_time", time_next, 64'd40);
    chk("t4b_hit", {60'd0, hit_mask}, 64'd2);
    chk("t4b_err", {63'd0, err_back}, 64'd1);
    set_times(64'd100, 64'd200, 64'd300, 64'd400);
    wait_step("t4c", 20, n);
    chk("t4c_time", time_next, 64'd100);
    chk("t4c_err", {63'd0, err_back}, 64'd1);

    // T5: reset during SCAN idx=2 discards the partial scan
    set_times(64'd70, 64'd80, 64'd90, 64'd75);
    repeat (4) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("t5_time", time_next, 64'd0);
    chk("t5_step", {63'd0, step}, 64'd0);
    chk("t5_hit", {60'd0, hit_mask}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_err", {63'd0, err_back}, 64'd0);
    rst = 1'b0;
    wait_step("t5", 20, n);
    chk("t5_lat", n, 64'd6);
    chk("t5_new_time", time_next, 64'd70);
    chk("t5_new_hit", {60'd0, hit_mask}, 64'd1);
    chk("t5_new_err", {63'd0, err_back}, 64'd0);

    // T6: stall during SETTLE parks the FSM in IDLE
    stall = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    watch(15, steps_seen, idle_seen);
    chk("t6_steps", steps_seen, 64'd0);
    chk("t6_idle", idle_seen, 64'd15);
    chk("t6_time", time_next, 64'd70);
    stall = 1'b0;
    wait_step("t6a", 20, n);
    chk("t6_resume_lat", n, 64'd6);
    wait_step("t6b", 20, n);
    chk("t6_period", n, 64'd7);

    // run dropped mid-scan: that scan still issues, then IDLE
    repeat (3) @(negedge clk_sys);
    run = 1'b0;
    wait_step("rd", 20, n);
    chk("rd_lat", n, 64'd4);
    chk("rd_time", time_next, 64'd70);
    repeat (3) @(negedge clk_sys);
    chk("rd_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
